// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling,
// saturating bubble counter and EX operand forwarding selects.
module id_ex_stage #(
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_d,
    input  logic [4:0]        ra1_d,
    input  logic [4:0]        ra2_d,
    input  logic [4:0]        wa_d,
    input  logic [63:0]       rd1_d,
    input  logic [63:0]       rd2_d,
    input  logic [63:0]       imm_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              regwrite_d,
    input  logic              memread_d,
    input  logic              flush_e,
    input  logic              mem_stall,
    input  logic [4:0]        wa_m,
    input  logic [4:0]        wa_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    output logic              valid_e,
    output logic              regwrite_e,
    output logic              memread_e,
    output logic [4:0]        ra1_e,
    output logic [4:0]        ra2_e,
    output logic [4:0]        wa_e,
    output logic [63:0]       rd1_e,
    output logic [63:0]       rd2_e,
    output logic [63:0]       imm_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic              stall_d,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [15:0]       bubble_cnt
);

    logic              r_valid_e;
    logic              r_regwrite_e;
    logic              r_memread_e;
    logic [4:0]        r_ra1_e;
    logic [4:0]        r_ra2_e;
    logic [4:0]        r_wa_e;
    logic [63:0]       r_rd1_e;
    logic [63:0]       r_rd2_e;
    logic [63:0]       r_imm_e;
    logic [CTRL_W-1:0] r_ctrl_e;
    logic [15:0]       r_bubble_cnt;

    logic w_hz;

    // X31 is XZR: a load targeting it can never feed a dependent instruction.
    assign w_hz = valid_d & r_valid_e & r_memread_e & r_regwrite_e & (r_wa_e != 5'd31) &
                  ((ra1_d == r_wa_e) | (ra2_d == r_wa_e));

    assign stall_d = mem_stall | (w_hz & ~flush_e);

    function automatic logic [1:0] fwd_sel(input logic [4:0] ra);
        if (regwrite_m && (wa_m == ra) && (ra != 5'd31))
            return 2'b10;
        else if (regwrite_w && (wa_w == ra) && (ra != 5'd31))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(r_ra1_e);
    assign fwd_b = fwd_sel(r_ra2_e);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_e    <= 1'b0;
            r_regwrite_e <= 1'b0;
            r_memread_e  <= 1'b0;
            r_ra1_e      <= '0;
            r_ra2_e      <= '0;
            r_wa_e       <= '0;
            r_rd1_e      <= '0;
            r_rd2_e      <= '0;
            r_imm_e      <= '0;
            r_ctrl_e     <= '0;
            r_bubble_cnt <= '0;
        end else if (!mem_stall) begin
            if (flush_e || w_hz) begin
                r_valid_e    <= 1'b0;
                r_regwrite_e <= 1'b0;
                r_memread_e  <= 1'b0;
                r_ra1_e      <= '0;
                r_ra2_e      <= '0;
                r_wa_e       <= '0;
                r_rd1_e      <= '0;
                r_rd2_e      <= '0;
                r_imm_e      <= '0;
                r_ctrl_e     <= '0;
                // Only hazard bubbles are counted; flush bubbles are not.
                if (!flush_e && (r_bubble_cnt != 16'hFFFF))
                    r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end else begin
                r_valid_e    <= valid_d;
                r_regwrite_e <= regwrite_d;
                r_memread_e  <= memread_d;
                r_ra1_e      <= ra1_d;
                r_ra2_e      <= ra2_d;
                r_wa_e       <= wa_d;
                r_rd1_e      <= rd1_d;
                r_rd2_e      <= rd2_d;
                r_imm_e      <= imm_d;
                r_ctrl_e     <= ctrl_d;
            end
        end
    end

    assign valid_e    = r_valid_e;
    assign regwrite_e = r_regwrite_e;
    assign memread_e  = r_memread_e;
    assign ra1_e      = r_ra1_e;
    assign ra2_e      = r_ra2_e;
    assign wa_e       = r_wa_e;
    assign rd1_e      = r_rd1_e;
    assign rd2_e      = r_rd2_e;
    assign imm_e      = r_imm_e;
    assign ctrl_e     = r_ctrl_e;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus hand sequences for
// load-use, XZR, flush, mem_stall, forwarding, saturation and reset.
module tb_id_ex_stage;

    localparam int CTRL_W = 12;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic [4:0]        ra1;
        logic [4:0]        ra2;
        logic [4:0]        wa;
        logic [63:0]       rd1;
        logic [63:0]       rd2;
        logic [63:0]       imm;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    typedef struct {
        ex_t  x;
        logic exp_stall;
    } vec_t;

    typedef struct {
        logic       rw_m;
        logic [4:0] wa_m;
        logic       rw_w;
        logic [4:0] wa_w;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } fvec_t;

    logic              clk;
    logic              reset_n;
    logic              valid_d;
    logic [4:0]        ra1_d, ra2_d, wa_d;
    logic [63:0]       rd1_d, rd2_d, imm_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              regwrite_d, memread_d;
    logic              flush_e, mem_stall;
    logic [4:0]        wa_m, wa_w;
    logic              regwrite_m, regwrite_w;
    logic              valid_e, regwrite_e, memread_e;
    logic [4:0]        ra1_e, ra2_e, wa_e;
    logic [63:0]       rd1_e, rd2_e, imm_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic              stall_d;
    logic [1:0]        fwd_a, fwd_b;
    logic [15:0]       bubble_cnt;

    logic [$bits(ex_t)-1:0] exp_q[$];
    int                     n_checks;
    int                     n_errors;
    logic [15:0]            exp_cnt;

    id_ex_stage #(.CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset_n(reset_n), .valid_d(valid_d),
        .ra1_d(ra1_d), .ra2_d(ra2_d), .wa_d(wa_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
        .regwrite_d(regwrite_d), .memread_d(memread_d),
        .flush_e(flush_e), .mem_stall(mem_stall),
        .wa_m(wa_m), .wa_w(wa_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .valid_e(valid_e), .regwrite_e(regwrite_e), .memread_e(memread_e),
        .ra1_e(ra1_e), .ra2_e(ra2_e), .wa_e(wa_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .ctrl_e(ctrl_e),
        .stall_d(stall_d), .fwd_a(fwd_a), .fwd_b(fwd_b), .bubble_cnt(bubble_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ex_t get_e();
        ex_t r;
        r.valid    = valid_e;
        r.regwrite = regwrite_e;
        r.memread  = memread_e;
        r.ra1      = ra1_e;
        r.ra2      = ra2_e;
        r.wa       = wa_e;
        r.rd1      = rd1_e;
        r.rd2      = rd2_e;
        r.imm      = imm_e;
        r.ctrl     = ctrl_e;
        return r;
    endfunction

    function automatic ex_t mk(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] w, input logic rw, input logic mr);
        ex_t r;
        r.valid    = v;
        r.regwrite = rw;
        r.memread  = mr;
        r.ra1      = a1;
        r.ra2      = a2;
        r.wa       = w;
        r.rd1      = {$urandom, $urandom};
        r.rd2      = {$urandom, $urandom};
        r.imm      = {$urandom, $urandom};
        r.ctrl     = CTRL_W'($urandom);
        return r;
    endfunction

    // driver tasks
    task automatic drive(input ex_t x);
        valid_d    = x.valid;
        regwrite_d = x.regwrite;
        memread_d  = x.memread;
        ra1_d      = x.ra1;
        ra2_d      = x.ra2;
        wa_d       = x.wa;
        rd1_d      = x.rd1;
        rd2_d      = x.rd2;
        imm_d      = x.imm;
        ctrl_d     = x.ctrl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard
    task automatic sb_pop(input string name);
        ex_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got empty queue expected entry", name);
        end else begin
            e = exp_q.pop_front();
            chk(name, 256'(get_e()), 256'(e));
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Load into EX targeting w, then a dependent instruction through one bubble.
    task automatic hazard_pair(input string name, input logic [4:0] w, input logic on_b);
        ex_t ld, dep;
        ld  = mk(1'b1, 5'd1, 5'd2, w, 1'b1, 1'b1);
        dep = on_b ? mk(1'b1, 5'd0, w, 5'd20, 1'b1, 1'b0) : mk(1'b1, w, 5'd0, 5'd20, 1'b1, 1'b0);
        drive(ld);
        exp_q.push_back(ld);
        tick();
        sb_pop({name, "_load"});
        drive(dep);
        #1;
        chk({name, "_stall"}, 256'(stall_d), 256'(1));
        exp_q.push_back('0);
        tick();
        sb_pop({name, "_bubble"});
        exp_cnt = sat_inc(exp_cnt);
        chk({name, "_cnt"}, 256'(bubble_cnt), 256'(exp_cnt));
        chk({name, "_stall_rel"}, 256'(stall_d), 256'(0));
        exp_q.push_back(dep);
        tick();
        sb_pop({name, "_dep"});
    endtask

    initial begin
        vec_t  tbl[12];
        fvec_t ftbl[5];
        ex_t   x, ld, dep;

        n_checks = 0;
        n_errors = 0;
        exp_cnt  = '0;
        reset_n  = 1'b0;
        drive('0);
        flush_e = 0; mem_stall = 0;
        wa_m = 0; wa_w = 0; regwrite_m = 0; regwrite_w = 0;

        // table of capture vectors; exp_stall marks the one load-use row
        tbl[0]  = '{mk(1, 5'd1,  5'd2,  5'd3,  1, 0), 1'b0};
        tbl[1]  = '{mk(1, 5'd3,  5'd4,  5'd5,  1, 1), 1'b0};
        tbl[2]  = '{mk(1, 5'd6,  5'd5,  5'd7,  1, 0), 1'b1};
        tbl[3]  = '{mk(1, 5'd5,  5'd5,  5'd9,  0, 0), 1'b0};
        tbl[4]  = '{mk(0, 5'd9,  5'd1,  5'd10, 1, 1), 1'b0};
        tbl[5]  = '{mk(1, 5'd10, 5'd10, 5'd11, 1, 0), 1'b0};
        tbl[6]  = '{mk(1, 5'd31, 5'd31, 5'd31, 1, 1), 1'b0};
        tbl[7]  = '{mk(1, 5'd31, 5'd0,  5'd1,  1, 0), 1'b0};
        tbl[8]  = '{mk(1, 5'd2,  5'd3,  5'd12, 0, 1), 1'b0};
        tbl[9]  = '{mk(1, 5'd12, 5'd12, 5'd13, 1, 1), 1'b0};
        tbl[10] = '{mk(0, 5'd13, 5'd13, 5'd14, 1, 0), 1'b0};
        tbl[11] = '{mk(1, 5'd14, 5'd13, 5'd15, 1, 0), 1'b0};

        // forwarding vectors with EX holding ra1=7, ra2=12
        ftbl[0] = '{1, 5'd7,  1, 5'd7,  2'b10, 2'b00};
        ftbl[1] = '{0, 5'd7,  1, 5'd7,  2'b01, 2'b00};
        ftbl[2] = '{1, 5'd12, 1, 5'd7,  2'b01, 2'b10};
        ftbl[3] = '{0, 5'd0,  0, 5'd0,  2'b00, 2'b00};
        ftbl[4] = '{1, 5'd7,  1, 5'd12, 2'b10, 2'b01};

        // reset state
        #12;
        chk("rst_e", 256'(get_e()), 256'(0));
        chk("rst_cnt", 256'(bubble_cnt), 256'(0));
        chk("rst_fwd", 256'({fwd_a, fwd_b}), 256'(0));
        @(negedge clk);
        reset_n = 1'b1;
        x = mk(1, 5'd4, 5'd5, 5'd6, 1, 1);
        drive(x);
        exp_q.push_back(x);
        tick();
        sb_pop("pre_rst_cap");
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_e", 256'(get_e()), 256'(0));
        chk("async_rst_fwd", 256'({fwd_a, fwd_b}), 256'(0));
        #1;
        reset_n = 1'b1;
        x = '0;
        x.valid = 1'b1;
        x.rd1 = 64'd35;
        drive(x);
        exp_q.push_back(x);
        tick();
        sb_pop("post_rst_rd1_35");

        // table-driven vectors
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].x);
            #1;
            chk($sformatf("tbl%0d_stall", i), 256'(stall_d), 256'(tbl[i].exp_stall));
            if (tbl[i].exp_stall) begin
                exp_q.push_back('0);
                tick();
                sb_pop($sformatf("tbl%0d_bubble", i));
                exp_cnt = sat_inc(exp_cnt);
                chk($sformatf("tbl%0d_cnt", i), 256'(bubble_cnt), 256'(exp_cnt));
            end
            exp_q.push_back(tbl[i].x);
            tick();
            sb_pop($sformatf("tbl%0d_cap", i));
        end
        chk("tbl_cnt_end", 256'(bubble_cnt), 256'(exp_cnt));

        // load-use on ra2 with the load now in WB
        hazard_pair("lu", 5'd5, 1'b1);
        regwrite_w = 1; wa_w = 5'd5;
        #1;
        chk("lu_fwd_b", 256'(fwd_b), 256'(2'b01));
        chk("lu_fwd_a", 256'(fwd_a), 256'(2'b00));
        regwrite_w = 0; wa_w = 0;

        // XZR: load to X31 never stalls nor forwards
        ld = mk(1, 5'd31, 5'd1, 5'd31, 1, 1);
        drive(ld);
        exp_q.push_back(ld);
        tick();
        sb_pop("xzr_load");
        dep = mk(1, 5'd31, 5'd0, 5'd2, 1, 0);
        drive(dep);
        regwrite_m = 1; wa_m = 5'd31;
        #1;
        chk("xzr_stall", 256'(stall_d), 256'(0));
        chk("xzr_fwd_a_load", 256'(fwd_a), 256'(2'b00));
        exp_q.push_back(dep);
        tick();
        sb_pop("xzr_no_bubble");
        chk("xzr_fwd_a", 256'(fwd_a), 256'(2'b00));
        chk("xzr_cnt", 256'(bubble_cnt), 256'(exp_cnt));
        regwrite_m = 0; wa_m = 0;

        // flush wins over hazard and is not counted
        ld = mk(1, 5'd1, 5'd2, 5'd5, 1, 1);
        drive(ld);
        exp_q.push_back(ld);
        tick();
        sb_pop("fl_load");
        drive(mk(1, 5'd5, 5'd0, 5'd6, 1, 0));
        flush_e = 1;
        #1;
        chk("fl_stall", 256'(stall_d), 256'(0));
        exp_q.push_back('0);
        tick();
        sb_pop("fl_bubble");
        flush_e = 0;
        chk("fl_cnt", 256'(bubble_cnt), 256'(exp_cnt));

        // mem_stall holds everything even with a hazard pending
        ld = mk(1, 5'd1, 5'd2, 5'd8, 1, 1);
        drive(ld);
        exp_q.push_back(ld);
        tick();
        sb_pop("ms_load");
        dep = mk(1, 5'd8, 5'd3, 5'd9, 1, 0);
        drive(dep);
        mem_stall = 1;
        #1;
        chk("ms_stall0", 256'(stall_d), 256'(1));
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(ld);
            tick();
            sb_pop($sformatf("ms_hold%0d", k));
            chk($sformatf("ms_stall%0d", k + 1), 256'(stall_d), 256'(1));
            chk($sformatf("ms_cnt%0d", k), 256'(bubble_cnt), 256'(exp_cnt));
            dep = mk(1, 5'd8, 5'($urandom_range(0, 30)), 5'($urandom_range(0, 30)), 1, 0);
            drive(dep);
        end
        mem_stall = 0;
        #1;
        chk("ms_rel_stall", 256'(stall_d), 256'(1));
        exp_q.push_back('0);
        tick();
        sb_pop("ms_rel_bubble");
        exp_cnt = sat_inc(exp_cnt);
        chk("ms_rel_cnt", 256'(bubble_cnt), 256'(exp_cnt));
        exp_q.push_back(dep);
        tick();
        sb_pop("ms_rel_dep");

        // forwarding priority table
        x = mk(1, 5'd7, 5'd12, 5'd3, 1, 0);
        drive(x);
        exp_q.push_back(x);
        tick();
        sb_pop("fwd_cap");
        for (int i = 0; i < 5; i++) begin
            regwrite_m = ftbl[i].rw_m; wa_m = ftbl[i].wa_m;
            regwrite_w = ftbl[i].rw_w; wa_w = ftbl[i].wa_w;
            #1;
            chk($sformatf("fwd%0d_a", i), 256'(fwd_a), 256'(ftbl[i].exp_a));
            chk($sformatf("fwd%0d_b", i), 256'(fwd_b), 256'(ftbl[i].exp_b));
        end
        regwrite_m = 0; wa_m = 0; regwrite_w = 0; wa_w = 0;

        // saturation: preload near the top, then two more hazards
        @(negedge clk);
        force dut.r_bubble_cnt = 16'hFFFE;
        #1;
        release dut.r_bubble_cnt;
        exp_cnt = 16'hFFFE;
        hazard_pair("sat1", 5'd9, 1'b0);
        hazard_pair("sat2", 5'd10, 1'b1);
        chk("sat_final", 256'(bubble_cnt), 256'(16'hFFFF));

        // reset asserted mid-stall
        mem_stall = 1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_ms_e", 256'(get_e()), 256'(0));
        chk("rst_ms_cnt", 256'(bubble_cnt), 256'(0));
        exp_cnt = '0;
        #1;
        reset_n = 1'b1;
        mem_stall = 0;
        x = mk(1, 5'd3, 5'd4, 5'd5, 1, 0);
        drive(x);
        exp_q.push_back(x);
        tick();
        sb_pop("rst_ms_cap");

        chk("q_empty", 256'(exp_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
